// File: rtl/sys_array_result_drain.sv
// Result drain for the systolic array: snapshots the M*K PE results on completion,
// streams them row-major as BW-word beats, then pulses a one-cycle clear to the array.
module sys_array_result_drain #(
  parameter int M  = 2,
  parameter int K  = 2,
  parameter int BW = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              arr_done,
  input  logic              arr_err,
  input  logic [M*K*32-1:0] pe_out,
  output logic              arr_clr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BW*32-1:0]  m_data,
  output logic [BW-1:0]     m_keep,
  output logic              m_last,
  output logic              m_err,
  output logic              busy
);

  localparam int NWORDS = M * K;
  localparam int NBEATS = (NWORDS + BW - 1) / BW;
  localparam int CW     = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR, S_WAIT_LOW} state_t;

  state_t            state_q, state_d;
  logic [M*K*32-1:0] snap_q, snap_d;
  logic              err_q, err_d;
  logic [CW-1:0]     ctr_q, ctr_d;

  logic fire;
  logic last_beat;

  assign fire      = (state_q == S_DRAIN) && m_ready;
  assign last_beat = (ctr_q == CW'(NBEATS - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      err_q   <= 1'b0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    err_d   = err_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      S_IDLE: begin
        if (arr_done) begin
          snap_d  = pe_out;
          err_d   = arr_err;
          ctr_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fire) begin
          ctr_d = ctr_q + CW'(1);
          if (last_beat) state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_WAIT_LOW;
      // A done level still high here belongs to the matrix just drained.
      S_WAIT_LOW: begin
        if (!arr_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_valid = (state_q == S_DRAIN);
    m_last  = (state_q == S_DRAIN) && last_beat;
    m_err   = (state_q == S_DRAIN) && err_q;
    arr_clr = (state_q == S_CLEAR);
    busy    = (state_q != S_IDLE);
    m_data  = '0;
    m_keep  = '0;
    if (state_q == S_DRAIN) begin
      for (int w = 0; w < BW; w++) begin
        if (int'(ctr_q) * BW + w < NWORDS) begin
          m_data[w*32 +: 32] = snap_q[(int'(ctr_q) * BW + w)*32 +: 32];
          m_keep[w]          = 1'b1;
        end
      end
    end
  end

endmodule
